// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: scan FSM state encoding and the blank BCD code shared by the scan controller
package display_scan_ctrl_pkg;
  typedef enum logic {ST_GUARD, ST_SHOW} state_t;
  localparam logic [3:0] BLANK = 4'hF;
endpackage

// File: rtl/display_scan_ctrl_refresh_prescaler.sv
// refresh_prescaler: per-digit slot counter (i_en gates counting) emitting o_slot_wrap and o_guard_done strobes
module refresh_prescaler
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_slot_wrap,
  output logic o_guard_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] r_cnt;
  assign o_slot_wrap = i_en && r_cnt == CW'(REFRESH_DIV - 1);
  assign o_guard_done = i_en && r_cnt == CW'(GUARD - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else if (o_slot_wrap) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scanner with guard band, per-frame snapshot and leading-zero suppression
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD = 500
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       lz_en,
  input  logic [4*DIGITS-1:0]        digits_in,
  input  logic [DIGITS-1:0]          dp_mask,
  output logic [3:0]                 bcd_out,
  output logic [DIGITS-1:0]          an_n,
  output logic                       dp_out,
  output logic [$clog2(DIGITS)-1:0]  digit_idx,
  output logic                       frame_tick
);
  localparam int IW = $clog2(DIGITS);
  state_t r_state, w_state_next;
  logic [4*DIGITS-1:0] r_snap_d, w_snap_d;
  logic [DIGITS-1:0] r_snap_dp, w_snap_dp, w_blank, w_an;
  logic [IW-1:0] w_idx_next;
  logic r_fresh, r_lz, w_lz, w_run, w_take, w_last, w_slot_wrap, w_guard_done;
  refresh_prescaler #(.REFRESH_DIV(REFRESH_DIV), .GUARD(GUARD)) u_prescaler (
    .clk(clk),
    .rst_n(rst_n),
    .i_en(en),
    .o_slot_wrap(w_slot_wrap),
    .o_guard_done(w_guard_done)
  );
  always_comb begin
    w_last = digit_idx == IW'(DIGITS - 1);
    w_take = en && (r_fresh || (w_slot_wrap && w_last));
    w_snap_d = w_take ? digits_in : r_snap_d;
    w_snap_dp = w_take ? dp_mask : r_snap_dp;
    w_idx_next = w_slot_wrap ? (w_last ? '0 : digit_idx + 1'b1) : digit_idx;
    w_state_next = w_guard_done ? ST_SHOW : w_slot_wrap ? ST_GUARD : r_state;
    w_lz = r_state == ST_GUARD ? lz_en : r_lz;
    w_run = 1'b1;
    w_blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_run = w_run && w_snap_d[4*i +: 4] == 4'd0 && !w_snap_dp[i];
      w_blank[i] = w_lz && w_run;
    end
    w_an = '1;
    w_an[w_idx_next] = !(en && w_state_next == ST_SHOW && !w_blank[w_idx_next]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_GUARD;
      r_snap_d <= '0;
      r_snap_dp <= '0;
      r_fresh <= 1'b1;
      r_lz <= 1'b0;
      digit_idx <= '0;
      an_n <= '1;
      bcd_out <= '0;
      dp_out <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      r_state <= w_state_next;
      an_n <= w_an;
      frame_tick <= w_slot_wrap && w_last;
      if (en) begin
        r_fresh <= 1'b0;
        r_snap_d <= w_snap_d;
        r_snap_dp <= w_snap_dp;
        digit_idx <= w_idx_next;
        bcd_out <= w_snap_d[4*w_idx_next +: 4];
        dp_out <= w_snap_dp[w_idx_next];
        if (r_state == ST_GUARD) r_lz <= lz_en;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized and directed checks of display_scan_ctrl against a slot-arithmetic reference model
module tb_display_scan_ctrl;
  localparam int GRD = 2;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, lz_en = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_mask = '0;
  logic [3:0] bcd_out, an_n;
  logic dp_out, frame_tick;
  logic [1:0] digit_idx;
  int checks = 0, fails = 0;
  int n = 0;
  logic [15:0] m_snap = '0;
  logic [3:0] m_dpm = '0;
  logic m_lz = 1'b0;
  logic [3:0] e_an = 4'hF, e_bcd = '0;
  logic e_dp = 1'b0, e_tick = 1'b0;
  logic [1:0] e_idx = '0;

  display_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(8), .GUARD(GRD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lz_en(lz_en), .digits_in(digits_in), .dp_mask(dp_mask),
    .bcd_out(bcd_out), .an_n(an_n), .dp_out(dp_out), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic bit blanked(input int idx, input logic [15:0] s, input logic [3:0] d, input logic lz);
    int p = 0;
    for (int i = 0; i < 4; i++) if (s[4*i +: 4] != 4'd0 || d[i]) p = i;
    return lz && idx > p;
  endfunction

  // n = enabled edges since reset; slot position and digit follow by plain division
  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; m_snap = '0; m_dpm = '0; m_lz = 1'b0;
      e_an = 4'hF; e_bcd = '0; e_dp = 1'b0; e_idx = '0; e_tick = 1'b0;
    end else if (en) begin
      n++;
      if (n == 1 || n % 32 == 0) begin m_snap = digits_in; m_dpm = dp_mask; end
      if (n % 8 == GRD) m_lz = lz_en;
      e_idx = 2'((n / 8) % 4);
      e_bcd = m_snap[4*e_idx +: 4];
      e_dp = m_dpm[e_idx];
      e_an = (n % 8 >= GRD && !blanked(int'(e_idx), m_snap, m_dpm, m_lz)) ? ~(4'b1 << e_idx) : 4'hF;
      e_tick = n % 32 == 0;
    end else begin
      e_an = 4'hF; e_tick = 1'b0;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; lz_en = 1'b0; digits_in = 16'h1234; dp_mask = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an_n, bcd_out, dp_out, digit_idx, frame_tick} !== {4'hF, 4'h0, 1'b0, 2'd0, 1'b0}) begin
      fails++; $display("FAIL reset_state: got an=%b bcd=%h dp=%b idx=%0d tick=%b, exp an=1111 bcd=0 dp=0 idx=0 tick=0", an_n, bcd_out, dp_out, digit_idx, frame_tick);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (an_n !== 4'hF || bcd_out !== 4'h4) begin
      fails++; $display("FAIL post_reset_guard: got an=%b bcd=%h, exp an=1111 bcd=4", an_n, bcd_out);
    end
    @(negedge clk);
    checks++;
    if (an_n !== 4'b1110 || bcd_out !== 4'h4) begin
      fails++; $display("FAIL first_show: got an=%b bcd=%h, exp an=1110 bcd=4", an_n, bcd_out);
    end
  endtask

  task automatic test_scan();
    int on_cnt[4] = '{0, 0, 0, 0};
    int frm = 0, run = 0;
    logic [3:0] prev_bcd = bcd_out;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      checks++;
      if ({an_n, bcd_out, dp_out, digit_idx, frame_tick} !== {e_an, e_bcd, e_dp, e_idx, e_tick}) begin
        fails++; $display("FAIL scan_model t=%0t: got an=%b bcd=%h dp=%b idx=%0d tick=%b, exp an=%b bcd=%h dp=%b idx=%0d tick=%b", $time, an_n, bcd_out, dp_out, digit_idx, frame_tick, e_an, e_bcd, e_dp, e_idx, e_tick);
      end
      if (bcd_out !== prev_bcd) begin
        checks++;
        if (an_n !== 4'hF) begin fails++; $display("FAIL bcd_change_while_lit: got an=%b, exp an=1111", an_n); end
      end
      prev_bcd = bcd_out;
      if (frame_tick) frm++;
      if (an_n === 4'hF) run++;
      else begin
        if (run > 0) begin
          checks++;
          if (run != GRD) begin fails++; $display("FAIL guard_gap: got %0d dark cycles, exp %0d", run, GRD); end
        end
        run = 0;
        if (frm == 1) for (int d = 0; d < 4; d++) if (an_n === ~(4'b1 << d)) on_cnt[d]++;
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (on_cnt[d] != 6) begin fails++; $display("FAIL digit_on_time d%0d: got %0d cycles, exp 6", d, on_cnt[d]); end
    end
  endtask

  task automatic test_lz();
    logic [3:0] lit, dpv;
    logic [3:0] val[4];
    for (int pass = 0; pass < 2; pass++) begin
      lz_en = 1'b1; digits_in = 16'h0070; dp_mask = pass == 0 ? 4'b0000 : 4'b0100;
      @(negedge clk);
      for (int k = 0; k < 80 && frame_tick !== 1'b1; k++) @(negedge clk);
      checks++;
      if (frame_tick !== 1'b1) begin fails++; $display("FAIL lz_wait_tick: got tick=%b, exp 1", frame_tick); end
      lit = '0; dpv = '0;
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        checks++;
        if ({an_n, bcd_out, dp_out, digit_idx, frame_tick} !== {e_an, e_bcd, e_dp, e_idx, e_tick}) begin
          fails++; $display("FAIL lz_model t=%0t: got an=%b bcd=%h dp=%b idx=%0d tick=%b, exp an=%b bcd=%h dp=%b idx=%0d tick=%b", $time, an_n, bcd_out, dp_out, digit_idx, frame_tick, e_an, e_bcd, e_dp, e_idx, e_tick);
        end
        for (int d = 0; d < 4; d++) if (an_n[d] === 1'b0) begin lit[d] = 1'b1; val[d] = bcd_out; dpv[d] = dp_out; end
      end
      checks++;
      if (lit !== (pass == 0 ? 4'b0011 : 4'b0111)) begin
        fails++; $display("FAIL lz_lit_digits pass%0d: got %b, exp %b", pass, lit, pass == 0 ? 4'b0011 : 4'b0111);
      end
      checks++;
      if (val[1] !== 4'h7 || val[0] !== 4'h0) begin
        fails++; $display("FAIL lz_values: got d1=%h d0=%h, exp d1=7 d0=0", val[1], val[0]);
      end
      if (pass == 1) begin
        checks++;
        if (val[2] !== 4'h0 || dpv !== 4'b0100) begin
          fails++; $display("FAIL lz_dp_digit: got d2=%h dp=%b, exp d2=0 dp=0100", val[2], dpv);
        end
      end
    end
  endtask

  task automatic test_tearing();
    logic [3:0] seq[6];
    logic [3:0] exp_seq[6] = '{4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
    logic [3:0] prev_an;
    int got = 0;
    lz_en = 1'b0; dp_mask = '0; digits_in = 16'h1234;
    @(negedge clk);
    for (int k = 0; k < 80 && frame_tick !== 1'b1; k++) @(negedge clk);
    for (int k = 0; k < 80 && digit_idx !== 2'd2; k++) @(negedge clk);
    checks++;
    if (digit_idx !== 2'd2) begin fails++; $display("FAIL tear_wait_idx: got %0d, exp 2", digit_idx); end
    digits_in = 16'h5678;
    prev_an = an_n;
    for (int k = 0; k < 100 && got < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({an_n, bcd_out, dp_out, digit_idx, frame_tick} !== {e_an, e_bcd, e_dp, e_idx, e_tick}) begin
        fails++; $display("FAIL tear_model t=%0t: got an=%b bcd=%h dp=%b idx=%0d tick=%b, exp an=%b bcd=%h dp=%b idx=%0d tick=%b", $time, an_n, bcd_out, dp_out, digit_idx, frame_tick, e_an, e_bcd, e_dp, e_idx, e_tick);
      end
      if (prev_an === 4'hF && an_n !== 4'hF) begin seq[got] = bcd_out; got++; end
      prev_an = an_n;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seq[i] !== exp_seq[i]) begin fails++; $display("FAIL tear_sequence[%0d]: got %h, exp %h", i, seq[i], exp_seq[i]); end
    end
  endtask

  task automatic test_en_pause();
    logic [1:0] hold;
    int cyc = 0;
    for (int k = 0; k < 40 && an_n === 4'hF; k++) @(negedge clk);
    checks++;
    if (an_n === 4'hF) begin fails++; $display("FAIL pause_wait_show: got an=%b, exp lit", an_n); end
    hold = digit_idx;
    en = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (an_n !== 4'hF || digit_idx !== hold || frame_tick !== 1'b0) begin
        fails++; $display("FAIL paused: got an=%b idx=%0d tick=%b, exp an=1111 idx=%0d tick=0", an_n, digit_idx, frame_tick, hold);
      end
    end
    en = 1'b1;
    repeat (40) begin
      @(negedge clk);
      checks++;
      if ({an_n, bcd_out, dp_out, digit_idx, frame_tick} !== {e_an, e_bcd, e_dp, e_idx, e_tick}) begin
        fails++; $display("FAIL resume_model t=%0t: got an=%b bcd=%h dp=%b idx=%0d tick=%b, exp an=%b bcd=%h dp=%b idx=%0d tick=%b", $time, an_n, bcd_out, dp_out, digit_idx, frame_tick, e_an, e_bcd, e_dp, e_idx, e_tick);
      end
    end
    for (int k = 0; k < 80 && frame_tick !== 1'b1; k++) @(negedge clk);
    do begin @(negedge clk); cyc++; end while (frame_tick !== 1'b1 && cyc < 100);
    checks++;
    if (cyc != 32) begin fails++; $display("FAIL tick_period: got %0d cycles, exp 32", cyc); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 100 && !(digit_idx === 2'd2 && an_n !== 4'hF); k++) @(negedge clk);
    checks++;
    if (!(digit_idx === 2'd2 && an_n !== 4'hF)) begin fails++; $display("FAIL rst_wait_show2: got idx=%0d an=%b, exp idx=2 lit", digit_idx, an_n); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({an_n, bcd_out, dp_out, digit_idx, frame_tick} !== {4'hF, 4'h0, 1'b0, 2'd0, 1'b0}) begin
      fails++; $display("FAIL mid_reset: got an=%b bcd=%h dp=%b idx=%0d tick=%b, exp an=1111 bcd=0 dp=0 idx=0 tick=0", an_n, bcd_out, dp_out, digit_idx, frame_tick);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if ({an_n, bcd_out, dp_out, digit_idx, frame_tick} !== {e_an, e_bcd, e_dp, e_idx, e_tick}) begin
        fails++; $display("FAIL random_model t=%0t: got an=%b bcd=%h dp=%b idx=%0d tick=%b, exp an=%b bcd=%h dp=%b idx=%0d tick=%b", $time, an_n, bcd_out, dp_out, digit_idx, frame_tick, e_an, e_bcd, e_dp, e_idx, e_tick);
      end
      if ($urandom_range(0, 7) == 0)
        for (int i = 0; i < 4; i++) digits_in[4*i +: 4] = $urandom_range(0, 2) == 0 ? 4'($urandom_range(0, 15)) : 4'd0;
      if ($urandom_range(0, 15) == 0) dp_mask = $urandom_range(0, 2) == 0 ? 4'($urandom_range(0, 15)) : 4'd0;
      if ($urandom_range(0, 11) == 0) lz_en = 1'($urandom_range(0, 1));
      en = $urandom_range(0, 9) != 0;
      rst_n = $urandom_range(0, 299) != 0;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_tearing();
    test_en_pause();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed 7-segment digits (2..8).
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot (>= GUARD+2).
REQ-003 Parameter GUARD, default 500, anti-ghosting cycles per slot with all anodes off (>= 1).
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 en  input  1  scan enable; 0 = freeze counters, anodes off.
REQ-007 lz_en  input  1  leading-zero suppression enable.
REQ-008 digits_in  input  4*DIGITS  BCD digits, digit 0 (rightmost) in bits [3:0].
REQ-009 dp_mask  input  DIGITS  decimal point request per digit, bit i = digit i.
REQ-010 bcd_out  output  4  BCD code of the active digit, to the external 7-segment decoder.
REQ-011 an_n  output  DIGITS  digit anode enables, one-hot active-low; all 1 = dark.
REQ-012 dp_out  output  1  decimal point for the active digit, active-high.
REQ-013 digit_idx  output  clog2(DIGITS)  index of the digit currently scanned.
REQ-014 frame_tick  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-015 All outputs SHALL be registered; no combinational input-to-output path.
REQ-016 Slot counter SHALL count 0..REFRESH_DIV-1 while en=1, then wrap to 0 and advance digit_idx.
REQ-017 digit_idx SHALL count 0..DIGITS-1 and wrap to 0.
REQ-018 FSM states: GUARD (slot count < GUARD, an_n all 1) and SHOW (slot count >= GUARD, an_n bit digit_idx = 0).
REQ-019 GUARD->SHOW when slot count reaches GUARD; SHOW->GUARD on slot wrap.
REQ-020 bcd_out and dp_out SHALL update on entry to GUARD, so they are stable for the entire SHOW phase.
REQ-021 digits_in and dp_mask SHALL be snapshotted on the cycle digit_idx wraps to 0; the entire frame displays the snapshot (no tearing).
REQ-022 lz_en=1: snapshot digits from DIGITS-1 downward that equal 0 up to the first nonzero SHALL be blanked (an_n stays all 1 in SHOW). Digit 0 is never blanked.
REQ-023 Suppression SHALL NOT blank a digit whose dp_mask bit is 1, nor any digit to its right.
REQ-024 BCD codes 10..15 SHALL pass through unchanged; blanking them is the decoder's job.
REQ-025 frame_tick SHALL be 1 for exactly the cycle in which digit_idx wraps DIGITS-1 -> 0.
REQ-026 en=0: an_n all 1 on the next edge; slot counter, digit_idx and snapshot hold; frame_tick 0.
REQ-027 en 0->1: scanning resumes from the held count, state re-derived from the count.
REQ-028 Change of lz_en mid-frame SHALL take effect at the next SHOW phase.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force: an_n all 1, bcd_out 0, dp_out 0, digit_idx 0, frame_tick 0, slot counter 0, state GUARD, snapshot all 0.
REQ-030 Reset SHALL override en and any mid-slot activity; first SHOW starts GUARD cycles after rst_n rises.
REQ-031 After reset the first snapshot SHALL be taken at the first rising edge with rst_n=1 and en=1.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding (GUARD, SHOW) and the BLANK code constant 4'hF.
REQ-033 One sub-module, refresh_prescaler, SHALL contain the slot counter and emit slot_wrap and guard_done strobes.
REQ-034 Target size 150-300 lines of RTL.

Verification (DIGITS=4, REFRESH_DIV=8, GUARD=2)
REQ-035 Reset, en=1, digits_in=16'h1234, lz_en=0 -> an_n cycles 1110,1101,1011,0111 with bcd_out 4,3,2,1; each digit active 6 of 8 cycles.
REQ-036 Slot boundary -> an_n=1111 for exactly 2 cycles between consecutive digits; bcd_out changes only while an_n=1111.
REQ-037 digits_in=16'h0070, lz_en=1, dp_mask=0 -> digits 3 and 2 dark, digits 1 and 0 show 7 and 0; dp_mask=4'b0100 -> digit 2 shows 0 with dp_out=1.
REQ-038 digits_in changed from 16'h1234 to 16'h5678 while digit_idx=2 -> rest of frame shows 2,1; next frame shows 8,7,6,5.
REQ-039 en=0 for 20 cycles mid-SHOW -> an_n=1111, digit_idx and counter frozen; resumes at same count; frame_tick every 32 enabled cycles.
REQ-040 rst_n=0 for one cycle mid-SHOW of digit 2 -> next cycle an_n=1111, digit_idx=0, bcd_out=0, frame_tick=0.
